program_loader: RTL and testbench

- Upstream of the pipelined MIPS core: turns a byte stream from a host link into instruction-memory load cycles.
- Drives the core's iInstAddr / iInstExt / iInstLd load port.
- Holds the core in reset until the whole image is written, then releases it so execution starts at the base address.
- Stream format: 4-byte little-endian word count, then that many instruction words, each little-endian.

---
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 151 +++++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Host byte stream in, instruction-memory load port and core control out.
// The loader sits on the slave side; the host/load-port owner is master.
interface program_loader_if #(
  parameter int unsigned WORD_SIZE = 32
) ();
  logic                 i_start;
  logic                 i_byte_valid;
  logic [7:0]           i_byte;
  logic                 o_byte_ready;
  logic [WORD_SIZE-1:0] o_InstAddr;
  logic [WORD_SIZE-1:0] o_InstExt;
  logic                 o_InstLd;
  logic                 o_cpu_rst;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  logic [10:0]          o_words_loaded;

  modport slave (
    input  i_start, i_byte_valid, i_byte,
    output o_byte_ready, o_InstAddr, o_InstExt, o_InstLd, o_cpu_rst,
    output o_busy, o_done, o_err, o_words_loaded
  );

  modport master (
    output i_start, i_byte_valid, i_byte,
    input  o_byte_ready, o_InstAddr, o_InstExt, o_InstLd, o_cpu_rst,
    input  o_busy, o_done, o_err, o_words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// Byte-stream program loader: header word count, then little-endian instruction words written
// to IMem one per WRITE cycle; holds the core in reset until the image is complete.
module program_loader #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned          MAX_WORDS = 1024,
  parameter int unsigned          RST_HOLD  = 4
) (
  input logic                  i_CLK,
  input logic                  i_RST_N,
  program_loader_if.slave      bus
);

  localparam int unsigned HoldW = $clog2(RST_HOLD + 2);

  typedef enum logic [2:0] {StIdle, StHdr, StLoad, StWrite, StDone, StErr} state_e;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [23:0]          asm_q, asm_d;
  logic [10:0]          cnt_q, cnt_d;
  logic [10:0]          words_q, words_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] inst_q, inst_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic                 ready_q, ready_d;
  logic                 ld_q, ld_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic        take;
  logic        word_done;
  logic [31:0] full_word;
  logic [10:0] words_inc;

  assign take      = bus.i_byte_valid & ready_q;
  assign word_done = take && (idx_q == 2'd3);
  // Fourth byte goes straight from the input so the word is usable on the edge it arrives.
  assign full_word = {bus.i_byte, asm_q};
  assign words_inc = words_q + 11'd1;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      asm_q     <= '0;
      cnt_q     <= '0;
      words_q   <= '0;
      addr_q    <= BASE_ADDR;
      inst_q    <= '0;
      hold_q    <= '0;
      ready_q   <= 1'b0;
      ld_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      ld_q      <= ld_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (bus.i_start) state_d = StHdr;
      StHdr: begin
        if (word_done) begin
          if (full_word == 32'd0)                  state_d = StDone;
          else if (full_word > 32'(MAX_WORDS))     state_d = StErr;
          else                                     state_d = StLoad;
        end
      end
      StLoad:  if (word_done) state_d = StWrite;
      StWrite: state_d = (words_inc == cnt_q) ? StDone : StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    hold_d  = hold_q;

    if (take) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0:    asm_d[7:0]   = bus.i_byte;
        2'd1:    asm_d[15:8]  = bus.i_byte;
        2'd2:    asm_d[23:16] = bus.i_byte;
        default: asm_d        = asm_q;
      endcase
    end

    if (state_q == StHdr && word_done)  cnt_d  = full_word[10:0];
    if (state_q == StLoad && word_done) inst_d = WORD_SIZE'(full_word);
    if (state_q == StWrite) begin
      addr_d  = addr_q + WORD_SIZE'(4);
      words_d = words_inc;
    end

    if (state_d == StHdr && state_q != StHdr) begin
      idx_d   = '0;
      asm_d   = '0;
      words_d = '0;
      addr_d  = BASE_ADDR;
    end

    if (state_d == StDone) begin
      if (state_q != StDone)                  hold_d = '0;
      else if (hold_q != HoldW'(RST_HOLD))    hold_d = hold_q + HoldW'(1);
    end

    ready_d   = (state_d == StHdr) || (state_d == StLoad);
    ld_d      = (state_d == StWrite);
    busy_d    = (state_d == StHdr) || (state_d == StLoad) || (state_d == StWrite);
    done_d    = (state_d == StDone);
    err_d     = (state_d == StErr);
    cpu_rst_d = !((state_d == StDone) && (hold_d == HoldW'(RST_HOLD)));
  end

  assign bus.o_byte_ready   = ready_q;
  assign bus.o_InstAddr     = addr_q;
  assign bus.o_InstExt      = inst_q;
  assign bus.o_InstLd       = ld_q;
  assign bus.o_cpu_rst      = cpu_rst_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_err          = err_q;
  assign bus.o_words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stimulus pushes expected IMem writes to a queue and a
// negedge monitor pops and compares each o_InstLd cycle.
module tb_program_loader;
  localparam logic [31:0] Base = 32'h0040_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.WORD_SIZE(32)) bus ();

  program_loader #(
    .WORD_SIZE(32),
    .BASE_ADDR(Base),
    .MAX_WORDS(1024),
    .RST_HOLD (4)
  ) dut (
    .i_CLK  (clk),
    .i_RST_N(rst_n),
    .bus    (bus.slave)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          ld_count = 0;
  logic        prev_ld  = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.o_InstLd) begin
      ld_count++;
      chk("ld_pulse_width", {31'd0, prev_ld}, 32'd0);
      chk("ready_in_write", {31'd0, bus.o_byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: addr %h data %h, none expected",
                 bus.o_InstAddr, bus.o_InstExt);
      end else begin
        e = exp_q.pop_front();
        chk("ld_addr", bus.o_InstAddr, e[63:32]);
        chk("ld_data", bus.o_InstExt, e[31:0]);
      end
    end
    prev_ld = bus.o_InstLd;
  end

  task automatic check_reset_vals();
    chk("rst_InstLd", {31'd0, bus.o_InstLd}, 32'd0);
    chk("rst_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
    chk("rst_addr", bus.o_InstAddr, Base);
    chk("rst_ext", bus.o_InstExt, 32'd0);
    chk("rst_done", {31'd0, bus.o_done}, 32'd0);
    chk("rst_err", {31'd0, bus.o_err}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_byte_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_words", {21'd0, bus.o_words_loaded}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) begin
      bus.i_start      = 1'($urandom);
      bus.i_byte_valid = 1'($urandom);
      bus.i_byte       = 8'($urandom);
      @(negedge clk);
    end
    check_reset_vals();
    bus.i_start      = 1'b0;
    bus.i_byte_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic r;
    bus.i_byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      r = bus.o_byte_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte %h not accepted, ready stayed %b", b, r);
        break;
      end
    end
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], int'($urandom_range(gapmax, 0)));
  endtask

  // Waits for o_done, checks the final count, then times the core-reset release.
  task automatic wait_done_release(input int exp_words);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_done && n < 200);
    chk("done_seen", {31'd0, bus.o_done}, 32'd1);
    chk("done_words", {21'd0, bus.o_words_loaded}, exp_words);
    chk("cpu_rst_at_done", {31'd0, bus.o_cpu_rst}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_cpu_rst && n < 20);
    chk("rst_hold_cycles", n, 32'd4);
    repeat (3) @(negedge clk);
    chk("cpu_rst_stays_low", {31'd0, bus.o_cpu_rst}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bus.i_start      = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    apply_reset();

    // Two-word image, back-to-back bytes.
    pulse_start();
    exp_q.push_back({Base, 32'h3C01_1001});
    exp_q.push_back({Base + 32'd4, 32'h0500_0820});
    send_word(32'd2, 0);
    send_word(32'h3C01_1001, 0);
    send_word(32'h0500_0820, 0);
    wait_done_release(2);

    // Same image with gaps; restart from DONE re-asserts core reset.
    pulse_start();
    chk("restart_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
    chk("restart_busy", {31'd0, bus.o_busy}, 32'd1);
    chk("restart_done_clr", {31'd0, bus.o_done}, 32'd0);
    chk("restart_words_clr", {21'd0, bus.o_words_loaded}, 32'd0);
    chk("restart_addr", bus.o_InstAddr, Base);
    exp_q.push_back({Base, 32'h3C01_1001});
    exp_q.push_back({Base + 32'd4, 32'h0500_0820});
    send_word(32'd2, 3);
    send_word(32'h3C01_1001, 3);
    send_word(32'h0500_0820, 3);
    wait_done_release(2);

    // Zero-length image.
    snap = ld_count;
    pulse_start();
    send_word(32'd0, 0);
    wait_done_release(0);
    chk("zero_no_load", ld_count, snap);

    // Oversize header (1025) lands in ERR and stays there.
    snap = ld_count;
    pulse_start();
    send_word(32'd1025, 1);
    @(negedge clk);
    chk("err_flag", {31'd0, bus.o_err}, 32'd1);
    chk("err_ready", {31'd0, bus.o_byte_ready}, 32'd0);
    chk("err_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
    chk("err_busy", {31'd0, bus.o_busy}, 32'd0);
    bus.i_byte       = 8'h5A;
    bus.i_byte_valid = 1'b1;
    repeat (8) @(negedge clk);
    bus.i_byte_valid = 1'b0;
    chk("err_hold_flag", {31'd0, bus.o_err}, 32'd1);
    chk("err_hold_cpu_rst", {31'd0, bus.o_cpu_rst}, 32'd1);
    chk("err_no_load", ld_count, snap);
    @(posedge clk);
    #1;
    pulse_start();
    chk("err_exit_clr", {31'd0, bus.o_err}, 32'd0);
    exp_q.push_back({Base, 32'h1234_5678});
    send_word(32'd1, 0);
    send_word(32'h1234_5678, 2);
    wait_done_release(1);

    // Exactly MAX_WORDS is accepted; reset mid-word then a clean reload.
    pulse_start();
    send_word(32'd1024, 0);
    @(negedge clk);
    chk("max_not_err", {31'd0, bus.o_err}, 32'd0);
    chk("max_busy", {31'd0, bus.o_busy}, 32'd1);
    chk("max_ready", {31'd0, bus.o_byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    apply_reset();
    exp_q.push_back({Base, 32'hAABB_CCDD});
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hAABB_CCDD, 1);
    wait_done_release(1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
